// File: rtl/insn_encoder.sv
// Retro16 instruction encoder: packs decoded fields into 16-bit words and writes them to program RAM at consecutive addresses.
// Latency 1 (accept -> mem_we); mem_we holds until mem_ready. Optional ENCODER_RANGE_CHECK_EN enables field range checks and err.
module insn_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [2:0]        cond,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        rd,
  input  logic [2:0]        ra,
  input  logic [2:0]        rb,
  input  logic [15:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]       NOP_WORD  = 16'h1000;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept, wr_done, last_pending, restart;
  logic [15:0]       enc_word, word;
  logic              err_q;

  // A pending write to the top address blocks new accepts so nothing lands past the end.
  assign last_pending = mem_we && (&mem_addr);
  assign in_ready     = (state == RUN) && (!mem_we || (mem_ready && !last_pending));
  assign accept       = in_valid && in_ready;
  assign wr_done      = mem_we && mem_ready;
  assign restart      = start && (state != RUN);
  assign busy         = (state == RUN);
  assign full         = (state == FULL);

  always_comb begin
    enc_word = NOP_WORD;
    case (kind)
      3'd0: enc_word = {1'b1, cond, imm[11:0]};
      3'd1: enc_word = {3'b010, rd, ra, imm[6:0]};
      3'd2: enc_word = {3'b011, ra, rb, imm[6:0]};
      3'd3: enc_word = {5'b00000, rd, ra, imm[4:0]};
      3'd4: enc_word = {5'b00001, alu_op, rd, ra, rb};
      3'd5: enc_word = {3'b001, alu_op, rd, ra, imm[4:0]};
      default: enc_word = NOP_WORD;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic enc_bad, fits12, fits7, fits5;

  assign fits12 = (imm[15:11] == {5{imm[11]}});
  assign fits7  = (imm[15:6]  == {10{imm[6]}});
  assign fits5  = (imm[15:4]  == {12{imm[4]}});

  always_comb begin
    enc_bad = 1'b0;
    case (kind)
      3'd0:      enc_bad = !fits12 || (cond[1:0] == 2'b11);
      3'd1, 3'd2: enc_bad = !fits7;
      3'd3, 3'd5: enc_bad = !fits5;
      3'd7:      enc_bad = 1'b1;
      default:   enc_bad = 1'b0;
    endcase
  end

  assign word = enc_bad ? NOP_WORD : enc_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (restart) begin
      err_q <= 1'b0;
    end else if (accept && enc_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  assign word  = enc_word;
  assign err_q = 1'b0;
`endif

  assign err = err_q;

  // start beats stop; start while already running is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (stop && !start)              state_nxt = IDLE;
        else if (wr_done && &mem_addr)   state_nxt = FULL;
      end
      FULL: begin
        if (start)      state_nxt = RUN;
        else if (stop)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_addr   <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= word;
        wr_addr   <= wr_addr + ADDR_ONE;
      end else if (wr_done) begin
        mem_we <= 1'b0;
      end
      if (restart) begin
        wr_addr <= base_addr;
        count   <= '0;
      end else if (wr_done) begin
        count <= count + COUNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Directed-vector bench for insn_encoder: an 8-bit-address instance for the main paths and a 2-bit-address instance for the FULL boundary.
module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, in_valid, in_valid_s, mem_ready;
  logic [7:0]  base_addr;
  logic [1:0]  base_addr_s;
  logic [2:0]  kind, cond, rd, ra, rb;
  logic [1:0]  alu_op;
  logic [15:0] imm;

  logic        in_ready, mem_we, busy, full, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  count;

  logic        in_ready_s, mem_we_s, busy_s, full_s, err_s;
  logic [1:0]  mem_addr_s;
  logic [15:0] mem_wdata_s;
  logic [2:0]  count_s;

  int vectors = 0;
  int miscompares = 0;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic [15:0] ALU_RI_EXP = 16'h1000;
  localparam logic        ERR_EXP    = 1'b1;
`else
  localparam logic [15:0] ALU_RI_EXP = 16'h2010;
  localparam logic        ERR_EXP    = 1'b0;
`endif

  always #5 clk = ~clk;

  insn_encoder #(.ADDR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .kind(kind), .cond(cond), .alu_op(alu_op),
    .rd(rd), .ra(ra), .rb(rb), .imm(imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .full(full), .err(err),
    .count(count)
  );

  insn_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .base_addr(base_addr_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .kind(kind), .cond(cond), .alu_op(alu_op),
    .rd(rd), .ra(ra), .rb(rb), .imm(imm), .mem_we(mem_we_s), .mem_ready(mem_ready),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .busy(busy_s), .full(full_s), .err(err_s),
    .count(count_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] k, input logic [2:0] c, input logic [1:0] op,
                            input logic [2:0] d, input logic [2:0] a, input logic [2:0] b,
                            input logic [15:0] i);
    kind = k; cond = c; alu_op = op; rd = d; ra = a; rb = b; imm = i;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({mem_we, in_ready, busy, full, err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b expected 00000", {mem_we, in_ready, busy, full, err});
    end
    vectors++;
    if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000 || count !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_regs got addr=%h data=%h count=%0d expected 0/0/0", mem_addr, mem_wdata, count);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    base_addr = 8'h10; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_run got busy=%b in_ready=%b expected 1/1", busy, in_ready);
    end
    set_fields(3'd1, 3'd0, 2'd0, 3'd3, 3'd5, 3'd0, 16'hFFFE);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 16'h4EFE) begin
      miscompares++;
      $display("FAIL load_word got we=%b addr=%h data=%h expected 1/10/4efe", mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if (in_ready !== 1'b0 || count !== 9'd0) begin
      miscompares++;
      $display("FAIL load_pending got in_ready=%b count=%0d expected 0/0", in_ready, count);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    vectors++;
    if (mem_we !== 1'b0 || count !== 9'd1) begin
      miscompares++;
      $display("FAIL load_done got we=%b count=%0d expected 0/1", mem_we, count);
    end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    set_fields(3'd4, 3'd0, 2'd2, 3'd1, 3'd2, 3'd3, 16'h0000);
    in_valid = 1'b1;
    tick();
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 16'h0C53) begin
      miscompares++;
      $display("FAIL b2b_alu_rr got we=%b addr=%h data=%h expected 1/11/0c53", mem_we, mem_addr, mem_wdata);
    end
    set_fields(3'd0, 3'd1, 2'd0, 3'd0, 3'd0, 3'd0, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h12 || mem_wdata !== 16'h9FFF) begin
      miscompares++;
      $display("FAIL b2b_branch got we=%b addr=%h data=%h expected 1/12/9fff", mem_we, mem_addr, mem_wdata);
    end
    tick();
    vectors++;
    if (mem_we !== 1'b0 || count !== 9'd3) begin
      miscompares++;
      $display("FAIL b2b_drain got we=%b count=%0d expected 0/3", mem_we, count);
    end
  endtask

  task automatic test_range();
    set_fields(3'd5, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0010);
    in_valid = 1'b1;
    tick();
    vectors++;
    if (mem_addr !== 8'h13 || mem_wdata !== ALU_RI_EXP || err !== ERR_EXP) begin
      miscompares++;
      $display("FAIL range_alu_ri got addr=%h data=%h err=%b expected 13/%h/%b",
               mem_addr, mem_wdata, err, ALU_RI_EXP, ERR_EXP);
    end
    set_fields(3'd7, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    tick();
    set_fields(3'd6, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    vectors++;
    if (mem_addr !== 8'h14 || mem_wdata !== 16'h1000 || err !== ERR_EXP) begin
      miscompares++;
      $display("FAIL range_kind7 got addr=%h data=%h err=%b expected 14/1000/%b", mem_addr, mem_wdata, err, ERR_EXP);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (count !== 9'd5 || err !== ERR_EXP) begin
      miscompares++;
      $display("FAIL range_sticky got count=%0d err=%b expected 5/%b", count, err, ERR_EXP);
    end
  endtask

  task automatic test_stall();
    mem_ready = 1'b0;
    set_fields(3'd2, 3'd0, 2'd0, 3'd0, 3'd2, 3'd4, 16'h0005);
    in_valid = 1'b1;
    tick();
    set_fields(3'd3, 3'd0, 2'd0, 3'd7, 3'd1, 3'd0, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 8'h15 || mem_wdata !== 16'h6A05 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got we=%b addr=%h data=%h in_ready=%b expected 1/15/6a05/0",
                 i, mem_we, mem_addr, mem_wdata, in_ready);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release got in_ready=%b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h16 || mem_wdata !== 16'h0723 || count !== 9'd6) begin
      miscompares++;
      $display("FAIL stall_replace got we=%b addr=%h data=%h count=%0d expected 1/16/0723/6",
               mem_we, mem_addr, mem_wdata, count);
    end
    tick();
    mem_ready = 1'b0;
    vectors++;
    if (mem_we !== 1'b0 || count !== 9'd7) begin
      miscompares++;
      $display("FAIL stall_count got we=%b count=%0d expected 0/7", mem_we, count);
    end
  endtask

  task automatic test_stop();
    set_fields(3'd6, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    in_valid = 1'b1;
    stop = 1'b1;
    tick();
    in_valid = 1'b0;
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h17) begin
      miscompares++;
      $display("FAIL stop_pending got busy=%b in_ready=%b we=%b addr=%h expected 0/0/1/17",
               busy, in_ready, mem_we, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    vectors++;
    if (mem_we !== 1'b0 || count !== 9'd8 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_drain got we=%b count=%0d busy=%b expected 0/8/0", mem_we, count, busy);
    end
  endtask

  task automatic test_full();
    base_addr_s = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    set_fields(3'd6, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    mem_ready = 1'b1;
    in_valid_s = 1'b1;
    tick();
    vectors++;
    if (mem_we_s !== 1'b1 || mem_addr_s !== 2'd2) begin
      miscompares++;
      $display("FAIL full_first got we=%b addr=%0d expected 1/2", mem_we_s, mem_addr_s);
    end
    tick();
    vectors++;
    if (mem_we_s !== 1'b1 || mem_addr_s !== 2'd3 || in_ready_s !== 1'b0) begin
      miscompares++;
      $display("FAIL full_last got we=%b addr=%0d in_ready=%b expected 1/3/0", mem_we_s, mem_addr_s, in_ready_s);
    end
    tick();
    vectors++;
    if (full_s !== 1'b1 || busy_s !== 1'b0 || mem_we_s !== 1'b0 || count_s !== 3'd2) begin
      miscompares++;
      $display("FAIL full_state got full=%b busy=%b we=%b count=%0d expected 1/0/0/2",
               full_s, busy_s, mem_we_s, count_s);
    end
    tick();
    vectors++;
    if (mem_we_s !== 1'b0 || in_ready_s !== 1'b0 || count_s !== 3'd2) begin
      miscompares++;
      $display("FAIL full_no_third got we=%b in_ready=%b count=%0d expected 0/0/2", mem_we_s, in_ready_s, count_s);
    end
    in_valid_s = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_setup got we=%b expected 1", mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_we, in_ready, busy, full, err} !== 5'b0 || mem_addr !== 8'h00 ||
        mem_wdata !== 16'h0000 || count !== 9'd0) begin
      miscompares++;
      $display("FAIL rst_mid_async got flags=%b addr=%h data=%h count=%0d expected 0/0/0/0",
               {mem_we, in_ready, busy, full, err}, mem_addr, mem_wdata, count);
    end
    #1 rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_idle got busy=%b in_ready=%b we=%b expected 0/0/0", busy, in_ready, mem_we);
    end
  endtask

  initial begin
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0; mem_ready = 1'b0;
    base_addr = 8'h00; base_addr_s = 2'd0;
    set_fields(3'd6, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    test_reset();
    test_load();
    test_back_to_back();
    test_range();
    test_stall();
    test_stop();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
